lot_occupancy_ctrl: RTL
=======================

LOT_OCCUPANCY_CTRL -- requirements
Module: lot_occupancy_ctrl

Interface
REQ-001 Parameter CAPACITY, default 99, maximum lot occupancy in the range 1..9999.
REQ-002 Parameter DB_CYCLES, default 500000, debounce stable-time in clk cycles (10 ms at 50 MHz).
REQ-003 clk  in  1  system clock; the only clock in the block.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 sensor_a  in  1  raw outer photo-sensor, asynchronous to clk; 1 = beam blocked.
REQ-006 sensor_b  in  1  raw inner photo-sensor, asynchronous to clk; 1 = beam blocked.
REQ-007 hex3, hex2, hex1, hex0  out  4 each  occupancy as BCD digits (thousands..units), feeding the display multiplexer.
REQ-008 dp_out  out  4  decimal-point controls, active-low (0 = lit).
REQ-009 car_enter  out  1  one-cycle pulse per completed entry.
REQ-010 car_exit  out  1  one-cycle pulse per completed exit.
REQ-011 full  out  1  high while occupancy == CAPACITY.
REQ-012 empty  out  1  high while occupancy == 0.

Function
REQ-013 Each sensor SHALL pass through a 2-flop synchronizer and then a debouncer.
REQ-014 Debouncer output SHALL change only after the synchronized input has differed from it for DB_CYCLES consecutive cycles; any glitch restarts the count.
REQ-015 The direction FSM SHALL act on debounced ab = {a,b}, with states IDLE, E1, E2, E3, X1, X2, X3.
REQ-016 IDLE transitions: ab=10 -> E1; ab=01 -> X1; ab=00 or 11 -> stay.
REQ-017 E1 transitions: 11 -> E2; 00 or 01 -> IDLE; 10 -> stay.
REQ-018 E2 transitions: 01 -> E3; 10 -> E1; 00 -> IDLE; 11 -> stay.
REQ-019 E3 transitions: 00 -> IDLE with a car_enter pulse; 11 -> E2; 10 -> IDLE; 01 -> stay.
REQ-020 X1/X2/X3 SHALL mirror E1/E2/E3 with a and b swapped, and X3 -> IDLE on 00 SHALL pulse car_exit.
REQ-021 car_enter and car_exit SHALL be registered, high for exactly one cycle, and never high together.
REQ-022 Occupancy SHALL be held as a 4-digit BCD counter, with each digit in 0..9 and carry/borrow between digits.
REQ-023 The counter update SHALL take effect on the clock edge that ends the cycle in which a pulse is high; hex outputs SHALL show the new value the following cycle.
REQ-024 An entry at occupancy == CAPACITY SHALL still pulse car_enter but leave the count unchanged.
REQ-025 An exit at occupancy == 0 SHALL still pulse car_exit but leave the count unchanged.
REQ-026 full and empty SHALL be decoded from the counter register, with no extra latency relative to the hex outputs.
REQ-027 dp_out SHALL equal 4'b1110 while full and 4'b1111 otherwise.
REQ-028 A reverse-direction sequence or an aborted sequence SHALL produce no pulse and no count change.

Reset
REQ-029 reset_n low SHALL immediately set:
- FSM = IDLE
- counter = 0, hex3..hex0 = 0
- car_enter = car_exit = 0
- full = 0, empty = 1, dp_out = 4'b1111
- synchronizer and debounce registers = 0, debounce counters = 0
REQ-030 Reset asserted mid-sequence SHALL discard the partial sequence with no pulse; after release the FSM starts from IDLE.

Structure
REQ-031 A shared package/include SHALL hold the FSM state encodings, the BCD digit width (4), and the DP pattern constants.
REQ-032 Debounce SHALL be a sub-module, sensor_debounce (parameter DB_CYCLES), instantiated once per sensor.
REQ-033 All outputs SHALL be register-driven or decoded only from registers, with no combinational path from the sensor inputs.

Verification
REQ-034 DB_CYCLES=4, CAPACITY=3; drive ab 00->10->11->01->00, each held 10 cycles -> exactly one car_enter pulse, hex0 0->1, empty falls.
REQ-035 From occupancy 1, drive 00->01->11->10->00 -> one car_exit pulse, hex0=0, empty=1.
REQ-036 Perform four entries with CAPACITY=3 -> four car_enter pulses, count stops at 3, full=1, dp_out=4'b1110.
REQ-037 Drive 00->10->11->10->00 (driver backs out), plus 2-cycle glitches on sensor_a -> no pulse, count unchanged.
REQ-038 With CAPACITY=9999, preload to 0099 via 99 entries, then one entry -> hex = 0,1,0,0; then one exit -> hex = 0,0,9,9.
REQ-039 Assert reset_n low while in E2 -> outputs at reset values immediately; completing the sequence after release yields no pulse.

Source files
------------

// File: rtl/lot_occupancy_ctrl_pkg.sv
// Shared definitions for the parking-lot occupancy controller: FSM states,
// BCD counter layout, decimal-point patterns and BCD arithmetic helpers.
package lot_occupancy_ctrl_pkg;

  localparam int BCD_W  = 4;
  localparam int DIGITS = 4;

  localparam logic [3:0] DP_FULL = 4'b1110;
  localparam logic [3:0] DP_OFF  = 4'b1111;

  typedef enum logic [2:0] {
    IDLE, E1, E2, E3, X1, X2, X3
  } dir_state_t;

  typedef logic [DIGITS*BCD_W-1:0] bcd_t;

  function automatic bcd_t to_bcd(input int value);
    bcd_t res;
    int   v;
    res = '0;
    v   = value;
    for (int i = 0; i < DIGITS; i++) begin
      res[i*BCD_W +: BCD_W] = BCD_W'(v % 10);
      v = v / 10;
    end
    return res;
  endfunction

  // Ripple carry digit by digit; a 9 rolls to 0 and passes the carry upward.
  function automatic bcd_t bcd_inc(input bcd_t value);
    bcd_t res;
    logic carry;
    res   = value;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (res[i*BCD_W +: BCD_W] == BCD_W'(9)) begin
          res[i*BCD_W +: BCD_W] = '0;
        end else begin
          res[i*BCD_W +: BCD_W] = res[i*BCD_W +: BCD_W] + 1'b1;
          carry = 1'b0;
        end
      end
    end
    return res;
  endfunction

  function automatic bcd_t bcd_dec(input bcd_t value);
    bcd_t res;
    logic borrow;
    res    = value;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (res[i*BCD_W +: BCD_W] == '0) begin
          res[i*BCD_W +: BCD_W] = BCD_W'(9);
        end else begin
          res[i*BCD_W +: BCD_W] = res[i*BCD_W +: BCD_W] - 1'b1;
          borrow = 1'b0;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchronizer followed by a stable-time debouncer for one
// photo-sensor input.
module sensor_debounce #(
  parameter int DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic stable
);

  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic [CNT_W-1:0] cnt;

  // NOTE: non-blocking assignments keep the synchronizer a true two-stage
  // shift; blocking ones would collapse it into a single flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      stable  <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
      // Any cycle where the input agrees with the output restarts the wait.
      if (sync_q2 != stable) begin
        if (cnt == CNT_LAST) begin
          stable <= sync_q2;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/lot_occupancy_ctrl.sv
// Parking-lot occupancy controller: decodes car direction from two beam
// sensors and keeps a saturating 4-digit BCD occupancy count.
module lot_occupancy_ctrl
  import lot_occupancy_ctrl_pkg::*;
#(
  parameter int CAPACITY  = 99,
  parameter int DB_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sensor_a,
  input  logic       sensor_b,
  output logic [3:0] hex3,
  output logic [3:0] hex2,
  output logic [3:0] hex1,
  output logic [3:0] hex0,
  output logic [3:0] dp_out,
  output logic       car_enter,
  output logic       car_exit,
  output logic       full,
  output logic       empty
);

  localparam bcd_t CAP_BCD = to_bcd(CAPACITY);

  logic       a_db;
  logic       b_db;
  logic [1:0] ab;
  dir_state_t state;
  bcd_t       count;

  sensor_debounce #(.DB_CYCLES(DB_CYCLES)) u_deb_a (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (sensor_a),
    .stable  (a_db)
  );

  sensor_debounce #(.DB_CYCLES(DB_CYCLES)) u_deb_b (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (sensor_b),
    .stable  (b_db)
  );

  assign ab = {a_db, b_db};

  // Entry walks 10 -> 11 -> 01 -> 00; exit is the same walk with a and b swapped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      car_enter <= 1'b0;
      car_exit  <= 1'b0;
    end else begin
      car_enter <= 1'b0;
      car_exit  <= 1'b0;
      case (state)
        IDLE: if (ab == 2'b10) state <= E1;
              else if (ab == 2'b01) state <= X1;
        E1:   if (ab == 2'b11) state <= E2;
              else if (ab != 2'b10) state <= IDLE;
        E2:   case (ab)
                2'b01:   state <= E3;
                2'b10:   state <= E1;
                2'b00:   state <= IDLE;
                default: state <= E2;
              endcase
        E3:   case (ab)
                2'b00:   begin state <= IDLE; car_enter <= 1'b1; end
                2'b11:   state <= E2;
                2'b10:   state <= IDLE;
                default: state <= E3;
              endcase
        X1:   if (ab == 2'b11) state <= X2;
              else if (ab != 2'b01) state <= IDLE;
        X2:   case (ab)
                2'b10:   state <= X3;
                2'b01:   state <= X1;
                2'b00:   state <= IDLE;
                default: state <= X2;
              endcase
        X3:   case (ab)
                2'b00:   begin state <= IDLE; car_exit <= 1'b1; end
                2'b11:   state <= X2;
                2'b01:   state <= IDLE;
                default: state <= X3;
              endcase
        default: state <= IDLE;
      endcase
    end
  end

  // Pulses are still issued at the limits; only the count saturates.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (car_enter && !full) begin
      count <= bcd_inc(count);
    end else if (car_exit && !empty) begin
      count <= bcd_dec(count);
    end
  end

  assign full   = (count == CAP_BCD);
  assign empty  = (count == '0);
  assign dp_out = full ? DP_FULL : DP_OFF;
  assign hex3   = count[3*BCD_W +: BCD_W];
  assign hex2   = count[2*BCD_W +: BCD_W];
  assign hex1   = count[1*BCD_W +: BCD_W];
  assign hex0   = count[0*BCD_W +: BCD_W];

endmodule
